// File: rtl/bp_update_controller_if.sv
// bp_update_controller_if
// Groups the signals between the branch-predictor update controller and
// its neighbours into one bundle.
//   Resolve channel (EX -> controller):
//     res_valid, res_PC, res_target, res_taken, pred_taken, pred_target
//     res_ready (controller -> EX)
//   BTB port:
//     hit_add_in (BTB -> controller): bit 3 = hit, bits 2:0 = entry index
//     PC_BP_wr, BTA_BP_wr, H_BP_wr, add_BP_wr, BP_write_enable
//   Front-end control (controller -> fetch):
//     flush, redirect_PC, mispredict_count
// The slave modport is the controller's view.
// The master modport is the surrounding pipeline/BTB view.
interface bp_update_controller_if;
    logic        res_valid;
    logic        res_ready;
    logic [15:0] res_PC;
    logic [15:0] res_target;
    logic        res_taken;
    logic        pred_taken;
    logic [15:0] pred_target;
    logic [3:0]  hit_add_in;
    logic [15:0] PC_BP_wr;
    logic [15:0] BTA_BP_wr;
    logic        H_BP_wr;
    logic [2:0]  add_BP_wr;
    logic        BP_write_enable;
    logic        flush;
    logic [15:0] redirect_PC;
    logic [7:0]  mispredict_count;

    modport slave (
        input  res_valid, res_PC, res_target, res_taken, pred_taken,
               pred_target, hit_add_in,
        output res_ready, PC_BP_wr, BTA_BP_wr, H_BP_wr, add_BP_wr,
               BP_write_enable, flush, redirect_PC, mispredict_count
    );

    modport master (
        output res_valid, res_PC, res_target, res_taken, pred_taken,
               pred_target, hit_add_in,
        input  res_ready, PC_BP_wr, BTA_BP_wr, H_BP_wr, add_BP_wr,
               BP_write_enable, flush, redirect_PC, mispredict_count
    );
endinterface

// File: rtl/bp_update_controller.sv
// bp_update_controller
// Takes one resolved-branch record at a time from EX.
//   - Flags a mispredict and requests a flush/redirect of the front end.
//   - Looks the branch PC up in the BTB.
//   - Updates the matching entry, or allocates a new entry round-robin for
//     taken branches that miss.
// Ports:
//   clock  : single clock, rising edge
//   reset  : synchronous, active-high
//   bus    : bp_update_controller_if.slave
//            (resolve channel, BTB port, flush/redirect, mispredict counter)
// Parameter:
//   ENTRIES : number of BTB entries; the allocation pointer is 3 bits.
module bp_update_controller #(
    parameter int ENTRIES = 8
) (
    input  logic clock,
    input  logic reset,
    bp_update_controller_if.slave bus
);

    typedef enum logic [1:0] {IDLE, LOOKUP, WRITE} state_t;

    state_t      state;
    state_t      state_next;

    logic [15:0] lat_target;
    logic        lat_taken;
    logic [2:0]  alloc_ptr;
    logic [2:0]  alloc_next;
    logic [2:0]  index_next;
    logic        do_write;
    logic        accept;
    logic        mispredict;
    logic [15:0] redirect_next;

    logic [15:0] pc_q;
    logic [15:0] bta_q;
    logic        hist_q;
    logic [2:0]  addr_q;
    logic        flush_q;
    logic [15:0] redirect_q;
    logic [7:0]  count_q;

    assign bus.res_ready        = (state == IDLE);
    assign accept               = bus.res_valid && (state == IDLE);

    // The strobe is gated by reset so that a reset arriving while in WRITE
    // abandons the update instead of letting the registered WRITE state leak a
    // strobe out during the reset cycle.
    assign bus.BP_write_enable  = (state == WRITE) && !reset;

    assign bus.PC_BP_wr         = pc_q;
    assign bus.BTA_BP_wr        = bta_q;
    assign bus.H_BP_wr          = hist_q;
    assign bus.add_BP_wr        = addr_q;
    assign bus.flush            = flush_q;
    assign bus.redirect_PC      = redirect_q;
    assign bus.mispredict_count = count_q;

    // Next-state logic and the decisions taken in each state.
    // The mispredict check is evaluated against the incoming record, because
    // it only matters in the cycle the record is accepted.
    // The LOOKUP decision picks the entry to write:
    //   - the hit index on a hit;
    //   - the allocation pointer for a taken miss.
    always_comb begin
        state_next    = state;
        index_next    = 3'd0;
        do_write      = 1'b0;
        alloc_next    = alloc_ptr;
        mispredict    = (bus.res_taken != bus.pred_taken) ||
                        (bus.res_taken && (bus.pred_target != bus.res_target));
        redirect_next = bus.res_taken ? bus.res_target : (bus.res_PC + 16'd1);

        case (state)
            IDLE: begin
                if (accept) begin
                    state_next = LOOKUP;
                end
            end
            LOOKUP: begin
                if (bus.hit_add_in[3]) begin
                    index_next = bus.hit_add_in[2:0];
                    do_write   = 1'b1;
                    state_next = WRITE;
                end else if (lat_taken) begin
                    index_next = alloc_ptr;
                    do_write   = 1'b1;
                    alloc_next = (alloc_ptr == 3'(ENTRIES - 1)) ? 3'd0 : alloc_ptr + 3'd1;
                    state_next = WRITE;
                end else begin
                    state_next = IDLE;
                end
            end
            WRITE: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // State register.
    always_ff @(posedge clock) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Datapath registers.
    // The record fields are captured on acceptance.
    // The flush pulse is produced by registering (accept && mispredict), so it
    // lasts exactly one cycle.
    // The BTB write fields are loaded on the LOOKUP->WRITE transition, so they
    // are stable while the strobe is high.
    always_ff @(posedge clock) begin
        if (reset) begin
            lat_target <= 16'h0000;
            lat_taken  <= 1'b0;
            alloc_ptr  <= 3'd0;
            pc_q       <= 16'h0000;
            bta_q      <= 16'h0000;
            hist_q     <= 1'b0;
            addr_q     <= 3'd0;
            flush_q    <= 1'b0;
            redirect_q <= 16'h0000;
            count_q    <= 8'h00;
        end else begin
            flush_q   <= accept && mispredict;
            alloc_ptr <= alloc_next;
            if (accept) begin
                pc_q       <= bus.res_PC;
                lat_target <= bus.res_target;
                lat_taken  <= bus.res_taken;
            end
            if (accept && mispredict) begin
                redirect_q <= redirect_next;
                if (count_q != 8'hFF) begin
                    count_q <= count_q + 8'd1;
                end
            end
            if (do_write) begin
                addr_q <= index_next;
                bta_q  <= lat_target;
                hist_q <= lat_taken;
            end
        end
    end

endmodule

// File: tb/tb_bp_update_controller.sv
// tb_bp_update_controller
// The bench drives resolved-branch records and emulates the BTB around the
// controller.
// A reference model predicts, per record:
//   - the flush/redirect/count event;
//   - the BTB write event.
// It does this from the branch-update rules directly, using a tag array, an
// allocation counter and a mispredict counter.
// Predicted events are queued with the cycle they must appear in.
// A monitor compares them with what the controller presents.
module tb_bp_update_controller;

    localparam int ENTRIES = 8;

    logic clock = 1'b0;
    logic reset = 1'b1;

    always #5 clock = ~clock;

    bp_update_controller_if bus();

    bp_update_controller #(.ENTRIES(ENTRIES)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    typedef struct {
        int          cyc;
        logic [15:0] a;
        logic [15:0] b;
        logic [7:0]  c;
    } ev_t;

    ev_t flush_q[$];
    ev_t write_q[$];

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    int          mdl_count = 0;
    int          mdl_alloc = 0;
    logic [15:0] mdl_tag [ENTRIES];
    logic [15:0] env_tag [ENTRIES] = '{default: 16'h0000};

    logic        ovr_en  = 1'b0;
    logic [3:0]  ovr_val = 4'b0000;
    logic [3:0]  hit_env;

    always @(posedge clock) cyc <= cyc + 1;

    // The BTB seen by the controller.
    // Tags start at zero, so PC 0 matches never-written entries.
    always @(posedge clock) begin
        if (bus.BP_write_enable) env_tag[bus.add_BP_wr] <= bus.PC_BP_wr;
    end

    always_comb begin
        hit_env = 4'b0000;
        for (int i = ENTRIES - 1; i >= 0; i--) begin
            if (env_tag[i] == bus.PC_BP_wr) hit_env = {1'b1, 3'(i)};
        end
    end

    assign bus.hit_add_in = ovr_en ? ovr_val : hit_env;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Offer one record and run the reference model on it, queuing the
    // expected flush and write events.
    // Then wait for res_ready to return and check the latency.
    task automatic applyStimulus(input logic [15:0] pc, input logic [15:0] target,
                                 input logic taken, input logic ptaken,
                                 input logic [15:0] ptarget,
                                 input logic oen, input logic [3:0] oval);
        int          acc;
        int          waited;
        int          exp_rel;
        logic [3:0]  hit;
        logic [2:0]  idx;
        logic        writes;
        logic [15:0] nxt;
        ev_t         e;

        @(negedge clock);
        bus.res_PC      = pc;
        bus.res_target  = target;
        bus.res_taken   = taken;
        bus.pred_taken  = ptaken;
        bus.pred_target = ptarget;
        ovr_en          = oen;
        ovr_val         = oval;
        bus.res_valid   = 1'b1;

        waited = 0;
        while (!bus.res_ready && waited < 20) begin
            @(negedge clock);
            waited++;
        end
        if (!bus.res_ready) begin
            checkOutput("accept_timeout", 32'(bus.res_ready), 32'd1);
            bus.res_valid = 1'b0;
            ovr_en = 1'b0;
            return;
        end
        acc = cyc + 1;

        nxt = pc + 16'd1;
        if ((taken != ptaken) || (taken && (ptarget != target))) begin
            if (mdl_count < 255) mdl_count++;
            e.cyc = acc;
            e.a   = taken ? target : nxt;
            e.b   = 16'h0000;
            e.c   = 8'(mdl_count);
            flush_q.push_back(e);
        end

        if (oen) begin
            hit = oval;
        end else begin
            hit = 4'b0000;
            for (int i = ENTRIES - 1; i >= 0; i--) begin
                if (mdl_tag[i] == pc) hit = {1'b1, 3'(i)};
            end
        end

        writes = 1'b1;
        idx = 3'd0;
        if (hit[3]) begin
            idx = hit[2:0];
        end else if (taken) begin
            idx = 3'(mdl_alloc);
            mdl_alloc = (mdl_alloc + 1) % ENTRIES;
        end else begin
            writes = 1'b0;
        end

        if (writes) begin
            mdl_tag[idx] = pc;
            e.cyc = acc + 1;
            e.a   = target;
            e.b   = pc;
            e.c   = {4'b0000, taken, idx};
            write_q.push_back(e);
        end
        exp_rel = writes ? 3 : 2;

        @(negedge clock);
        bus.res_valid = 1'b0;
        waited = 0;
        while (!bus.res_ready && waited < 20) begin
            @(negedge clock);
            waited++;
        end
        checkOutput("ready_latency", 32'(cyc - acc + 1), 32'(exp_rel));
        ovr_en = 1'b0;
    endtask

    // Take a taken-miss record into WRITE, then assert reset there while
    // offering another (mispredicting) record.
    task automatic resetMidWrite();
        int acc;

        @(negedge clock);
        bus.res_PC      = 16'h9000;
        bus.res_target  = 16'h9100;
        bus.res_taken   = 1'b1;
        bus.pred_taken  = 1'b1;
        bus.pred_target = 16'h9100;
        ovr_en          = 1'b1;
        ovr_val         = 4'b0000;
        bus.res_valid   = 1'b1;
        #1;
        checkOutput("rst_test_ready", 32'(bus.res_ready), 32'd1);
        acc = cyc + 1;

        @(negedge clock);
        bus.res_valid = 1'b0;
        #1;
        checkOutput("rst_test_lookup_ready", 32'(bus.res_ready), 32'd0);

        @(negedge clock);
        checkOutput("rst_test_in_write_cyc", 32'(cyc), 32'(acc + 1));
        reset           = 1'b1;
        bus.res_PC      = 16'hA000;
        bus.res_target  = 16'hA100;
        bus.res_taken   = 1'b1;
        bus.pred_taken  = 1'b0;
        bus.pred_target = 16'h0000;
        bus.res_valid   = 1'b1;
        #1;
        checkOutput("rst_write_pc", 32'(bus.PC_BP_wr), 32'h9000);
        checkOutput("rst_write_addr", 32'(bus.add_BP_wr), 32'(mdl_alloc));
        checkOutput("rst_we_suppressed", 32'(bus.BP_write_enable), 32'd0);

        @(negedge clock);
        reset = 1'b0;
        bus.res_valid = 1'b0;
        #1;
        checkOutput("rst_after_ready", 32'(bus.res_ready), 32'd1);
        checkOutput("rst_after_flush", 32'(bus.flush), 32'd0);
        checkOutput("rst_after_we", 32'(bus.BP_write_enable), 32'd0);
        checkOutput("rst_after_pc", 32'(bus.PC_BP_wr), 32'd0);
        checkOutput("rst_after_bta", 32'(bus.BTA_BP_wr), 32'd0);
        checkOutput("rst_after_redirect", 32'(bus.redirect_PC), 32'd0);
        checkOutput("rst_after_h", 32'(bus.H_BP_wr), 32'd0);
        checkOutput("rst_after_add", 32'(bus.add_BP_wr), 32'd0);
        checkOutput("rst_after_count", 32'(bus.mispredict_count), 32'd0);
        mdl_count = 0;
        mdl_alloc = 0;
        ovr_en    = 1'b0;

        @(negedge clock);
        #1;
        checkOutput("rst_record_not_taken", 32'(bus.res_ready), 32'd1);
    endtask

    // Monitor.
    // Whenever the controller presents a flush or a write strobe, pop the
    // oldest expected event and compare it.
    // An expected event whose cycle has passed unseen is reported as missing.
    initial begin
        ev_t e;
        forever begin
            @(negedge clock);
            #1;
            if (bus.flush) begin
                if (flush_q.size() == 0) begin
                    checkOutput("flush_unexpected", 32'(bus.flush), 32'd0);
                end else begin
                    e = flush_q.pop_front();
                    checkOutput("flush_cycle", 32'(cyc), 32'(e.cyc));
                    checkOutput("redirect_PC", 32'(bus.redirect_PC), 32'(e.a));
                    checkOutput("mispredict_count", 32'(bus.mispredict_count), 32'(e.c));
                end
            end
            if (flush_q.size() > 0 && flush_q[0].cyc < cyc) begin
                e = flush_q.pop_front();
                checkOutput("flush_missing_cycle", 32'(cyc), 32'(e.cyc));
            end
            if (bus.BP_write_enable) begin
                if (write_q.size() == 0) begin
                    checkOutput("write_unexpected", 32'(bus.BP_write_enable), 32'd0);
                end else begin
                    e = write_q.pop_front();
                    checkOutput("write_cycle", 32'(cyc), 32'(e.cyc));
                    checkOutput("BTA_BP_wr", 32'(bus.BTA_BP_wr), 32'(e.a));
                    checkOutput("PC_BP_wr", 32'(bus.PC_BP_wr), 32'(e.b));
                    checkOutput("H_add_BP_wr", 32'({bus.H_BP_wr, bus.add_BP_wr}), 32'(e.c));
                end
            end
            if (write_q.size() > 0 && write_q[0].cyc < cyc) begin
                e = write_q.pop_front();
                checkOutput("write_missing_cycle", 32'(cyc), 32'(e.cyc));
            end
        end
    end

    initial begin
        logic [15:0] tgt;

        for (int i = 0; i < ENTRIES; i++) mdl_tag[i] = 16'h0000;
        bus.res_valid   = 1'b0;
        bus.res_PC      = 16'h0000;
        bus.res_target  = 16'h0000;
        bus.res_taken   = 1'b0;
        bus.pred_taken  = 1'b0;
        bus.pred_target = 16'h0000;

        repeat (3) @(negedge clock);
        #1;
        checkOutput("reset_flush", 32'(bus.flush), 32'd0);
        checkOutput("reset_we", 32'(bus.BP_write_enable), 32'd0);
        checkOutput("reset_count", 32'(bus.mispredict_count), 32'd0);
        checkOutput("reset_pc", 32'(bus.PC_BP_wr), 32'd0);
        checkOutput("reset_redirect", 32'(bus.redirect_PC), 32'd0);
        @(negedge clock);
        reset = 1'b0;
        @(negedge clock);
        #1;
        checkOutput("ready_after_reset", 32'(bus.res_ready), 32'd1);

        // Miss-allocate, hit-update, correct not-taken miss, PC wrap on redirect
        applyStimulus(16'h0010, 16'h0040, 1'b1, 1'b0, 16'h0000, 1'b1, 4'b0000);
        applyStimulus(16'h0010, 16'h0077, 1'b0, 1'b1, 16'h0000, 1'b1, 4'b1101);
        applyStimulus(16'h0020, 16'h0050, 1'b0, 1'b0, 16'h0000, 1'b1, 4'b0000);
        applyStimulus(16'hFFFF, 16'h1234, 1'b0, 1'b1, 16'h0000, 1'b1, 4'b0000);
        // PC 0 matches a never-written entry through the emulated BTB
        applyStimulus(16'h0000, 16'h0300, 1'b1, 1'b1, 16'h0300, 1'b0, 4'b0000);

        resetMidWrite();

        // Nine taken misses after reset: the ninth wraps back to index 0
        for (int i = 0; i < 9; i++) begin
            applyStimulus(16'h8000 + 16'(i), 16'h8800 + 16'(i), 1'b1, 1'b1,
                          16'h8800 + 16'(i), 1'b1, 4'b0000);
        end

        for (int i = 0; i < 80; i++) begin
            tgt = 16'($urandom);
            applyStimulus(16'h0100 + 16'($urandom_range(0, 15)), tgt,
                          1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                          ($urandom_range(0, 2) == 0) ? 16'($urandom) : tgt,
                          1'b0, 4'b0000);
        end

        // Drive the counter into saturation
        for (int i = 0; i < 300; i++) begin
            applyStimulus(16'h0100 + 16'($urandom_range(0, 31)), 16'($urandom),
                          1'b0, 1'b1, 16'h0000, 1'b0, 4'b0000);
        end
        // Target-only mispredict still flushes
        applyStimulus(16'h0050, 16'h0040, 1'b1, 1'b1, 16'h0041, 1'b1, 4'b0000);

        repeat (4) @(negedge clock);
        checkOutput("flush_queue_drained", 32'(flush_q.size()), 32'd0);
        checkOutput("write_queue_drained", 32'(write_q.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/bp_update_controller.md
BP_UPDATE_CONTROLLER -- requirements
Module: bp_update_controller

Interface
REQ-001 Parameter ENTRIES, default 8, number of branch-target-buffer entries; allocation pointer width is 3 bits.
REQ-002 clock  input  1  single clock; all state changes on posedge clock.
REQ-003 reset  input  1  synchronous, active-high reset, sampled on posedge clock.
REQ-004 res_valid  input  1  resolved-branch record from EX is present this cycle.
REQ-005 res_ready  output  1  controller can accept a record; high only in IDLE.
REQ-006 res_PC  input  16  PC of the resolved branch.
REQ-007 res_target  input  16  actual branch target address.
REQ-008 res_taken  input  1  actual branch outcome, 1 = taken.
REQ-009 pred_taken  input  1  history bit predicted at fetch and carried down the pipeline.
REQ-010 pred_target  input  16  target predicted at fetch.
REQ-011 hit_add_in  input  4  BTB match result for PC_BP_wr: bit 3 = hit, bits 2:0 = entry index.
REQ-012 PC_BP_wr  output  16  PC driven to the BTB write/match port.
REQ-013 BTA_BP_wr  output  16  target written to the BTB.
REQ-014 H_BP_wr  output  1  history bit written to the BTB.
REQ-015 add_BP_wr  output  3  BTB entry index written.
REQ-016 BP_write_enable  output  1  one-cycle BTB write strobe.
REQ-017 flush  output  1  one-cycle pulse; squash younger instructions after a mispredict.
REQ-018 redirect_PC  output  16  corrected fetch PC; valid while flush is high.
REQ-019 mispredict_count  output  8  saturating count of mispredicts.

Function
REQ-020 States are IDLE, LOOKUP and WRITE; res_ready = (state == IDLE).
REQ-021 Acceptance occurs when res_valid and res_ready are both high; res_PC, res_target and res_taken are latched; state goes to LOOKUP.
REQ-022 res_valid while not in IDLE is ignored; upstream holds the record until res_ready is high.
REQ-023 Mispredict is computed at acceptance: (res_taken != pred_taken) or (res_taken and pred_target != res_target).
REQ-024 On a mispredict, flush is high for exactly the cycle after acceptance.
REQ-025 While flush is high, redirect_PC = latched target if taken, else latched PC + 1, with 16-bit wrap (16'hFFFF + 1 = 16'h0000).
REQ-026 When no flush is issued, flush is 0 and redirect_PC holds its previous value.
REQ-027 On a mispredict, mispredict_count increments one cycle after acceptance; it saturates at 8'hFF.
REQ-028 In LOOKUP and WRITE, PC_BP_wr = latched PC; in IDLE, PC_BP_wr holds its last value.
REQ-029 In LOOKUP, hit_add_in is sampled and the following is decided:
- hit: index = hit_add_in[2:0], go to WRITE;
- miss and taken: index = alloc_ptr, alloc_ptr increments modulo ENTRIES (7 wraps to 0), go to WRITE;
- miss and not taken: no write, go to IDLE.
REQ-030 In WRITE, the outputs are driven as follows, then the state goes to IDLE:
- BP_write_enable = 1 for that single cycle;
- add_BP_wr = index, BTA_BP_wr = latched target, H_BP_wr = latched taken.
REQ-031 A not-taken hit updates the entry: H_BP_wr = 0 and BTA_BP_wr = latched target.
REQ-032 BP_write_enable is 0 in every state except WRITE.
REQ-033 Per-record latency:
- acceptance = cycle 0;
- flush and LOOKUP = cycle 1;
- write strobe = cycle 2;
- res_ready high again = cycle 3 (cycle 2 if no write is needed).
REQ-034 PC 16'h0000 matches any never-written BTB entry; such a match is treated as an ordinary hit.

Reset
REQ-035 Reset drives the following, with priority over all other activity:
- state = IDLE, alloc_ptr = 0, mispredict_count = 0;
- flush = 0, BP_write_enable = 0;
- PC_BP_wr, BTA_BP_wr, redirect_PC = 16'h0000;
- H_BP_wr = 0, add_BP_wr = 0.
REQ-036 Reset in LOOKUP or WRITE abandons the record with no write strobe; the next cycle is IDLE with res_ready = 1.
REQ-037 res_ready is high in the first cycle after reset deasserts.

Verification
REQ-038 Miss-allocate: accept PC=0x0010, target=0x0040, taken=1, pred_taken=0, hit_add_in=4'b0000 -> expected:
- cycle 1: flush = 1, redirect_PC = 0x0040, count = 1;
- cycle 2: write to index 0 with H = 1, BTA = 0x0040;
- alloc_ptr = 1.
REQ-039 Hit-update: accept PC=0x0010, taken=0, pred_taken=1, hit_add_in=4'b1101 -> expected:
- flush = 1, redirect_PC = 0x0011;
- write to index 5 with H = 0;
- alloc_ptr unchanged.
REQ-040 Correct not-taken miss: accept PC=0x0020, taken=0, pred_taken=0, hit_add_in=0 -> expected:
- no flush and no write strobe;
- res_ready high at cycle 2.
REQ-041 Wrap/saturation, part 1: 9 taken misses -> the 9th allocation uses index 0.
REQ-042 Wrap/saturation, part 2: 300 mispredicts -> mispredict_count = 8'hFF; a target-only mispredict (taken both, pred_target=0x0041, target=0x0040) -> flush.
REQ-043 Reset mid-operation: assert reset in WRITE -> expected:
- no BP_write_enable;
- all outputs zero next cycle;
- a record offered during reset is not accepted.
